// File: rtl/efuse_pkg.sv
// efuse_pkg: shared eFuse widths, read FSM states and a small timing helper.
package efuse_pkg;
    localparam int EFUSE_ADDR_W = 8;
    localparam int EFUSE_BYTE_W = 8;
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} efuse_rd_st_e;
    function automatic int max1(input int v);
        return v < 1 ? 1 : v;
    endfunction
endpackage

// File: rtl/efuse_phase_timer.sv
// efuse_phase_timer: loadable down-counter that flags expiry on its final count.
module efuse_phase_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= load ? load_val : (cnt != '0 ? cnt - W'(1) : cnt);
    end
    assign expired = cnt == '0;
endmodule

// File: rtl/efuse_read_ctrl.sv
// efuse_read_ctrl: sequences one NR-bit word read from a byte-wide eFuse macro.
module efuse_read_ctrl
    import efuse_pkg::*;
#(
    parameter int NR         = 64,
    parameter int MEM_BYTES  = 32,
    parameter int TRD_W      = 6,
    parameter int TGAP_W     = 4,
    parameter int BYTE_ORDER = 0,
    localparam int BYTE_NUM  = NR / 8,
    localparam int RSEL      = (MEM_BYTES + BYTE_NUM - 1) / BYTE_NUM,
    localparam int SEL_W     = RSEL > 1 ? $clog2(RSEL) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [TRD_W-1:0]        rg_efuse_trd,
    input  logic [TGAP_W-1:0]       rg_efuse_tgap,
    input  logic [SEL_W-1:0]        read_sel,
    input  logic                    read_start,
    input  logic                    read_abort,
    output logic                    read_done,
    output logic                    read_err,
    output logic [NR-1:0]           read_data,
    output logic                    busy_read,
    output logic                    efuse_pgmen_o,
    output logic                    efuse_rden_o,
    output logic                    efuse_aen_o,
    output logic [EFUSE_ADDR_W-1:0] efuse_addr_o,
    input  logic [EFUSE_BYTE_W-1:0] efuse_rdata
);
    localparam int CNT_W = TRD_W > TGAP_W ? TRD_W : TGAP_W;
    localparam int IDX_W = BYTE_NUM > 1 ? $clog2(BYTE_NUM) : 1;

    efuse_rd_st_e     state;
    logic [CNT_W-1:0] t_m1, g_m1, load_val;
    logic [IDX_W-1:0] idx;
    logic             oor_q, load, expired, last, in_range;
    logic [NR-1:0]    shifted;
    int               base;

    assign efuse_pgmen_o = 1'b0;

    always_comb begin
        base     = BYTE_NUM * int'(read_sel);
        in_range = int'(read_sel) < RSEL && base + BYTE_NUM <= MEM_BYTES;
        last     = idx == IDX_W'(BYTE_NUM - 1);
        load     = state == SETUP || (state == STROBE && expired) || (state == GAP && expired && !last);
        load_val = state == STROBE ? g_m1 : t_m1;
        shifted  = BYTE_ORDER == 0 ? (read_data << 8) | NR'(efuse_rdata)
                                   : (read_data >> 8) | (NR'(efuse_rdata) << (NR - 8));
    end

    efuse_phase_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .expired  (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            t_m1         <= '0;
            g_m1         <= '0;
            idx          <= '0;
            oor_q        <= 1'b0;
            read_done    <= 1'b0;
            read_err     <= 1'b0;
            read_data    <= '0;
            busy_read    <= 1'b0;
            efuse_rden_o <= 1'b0;
            efuse_aen_o  <= 1'b0;
            efuse_addr_o <= '0;
        end else if (state != IDLE && read_abort) begin
            state        <= IDLE;
            efuse_aen_o  <= 1'b0;
            efuse_rden_o <= 1'b0;
            busy_read    <= 1'b0;
            read_data    <= '0;
            read_err     <= 1'b1;
            read_done    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (read_start && !read_abort) begin
                    state     <= SETUP;
                    busy_read <= 1'b1;
                    read_done <= 1'b0;
                    read_err  <= 1'b0;
                    read_data <= '0;
                    t_m1      <= CNT_W'(max1(int'(rg_efuse_trd)));
                    g_m1      <= CNT_W'(max1(int'(rg_efuse_tgap)) - 1);
                    idx       <= '0;
                    oor_q     <= !in_range;
                    // an out-of-range request never touches the macro pins
                    if (in_range) begin
                        efuse_rden_o <= 1'b1;
                        efuse_addr_o <= EFUSE_ADDR_W'(base);
                    end
                end
                SETUP: if (oor_q) begin
                    state     <= IDLE;
                    busy_read <= 1'b0;
                    read_err  <= 1'b1;
                    read_done <= 1'b1;
                end else begin
                    state       <= STROBE;
                    efuse_aen_o <= 1'b1;
                end
                STROBE: if (expired) begin
                    state       <= GAP;
                    efuse_aen_o <= 1'b0;
                    read_data   <= shifted;
                end
                GAP: if (expired) begin
                    if (last) begin
                        state        <= IDLE;
                        efuse_rden_o <= 1'b0;
                        busy_read    <= 1'b0;
                        read_done    <= 1'b1;
                    end else begin
                        state        <= STROBE;
                        efuse_aen_o  <= 1'b1;
                        efuse_addr_o <= efuse_addr_o + EFUSE_ADDR_W'(1);
                        idx          <= idx + IDX_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_efuse_read_ctrl.sv
// tb_efuse_read_ctrl: randomized reads against a byte-array macro model and cycle-level timing rules.
module tb_efuse_read_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [5:0] trd = '0;
    logic [3:0] tgap = '0;
    int tests = 0;
    int fails = 0;

    logic [7:0] mem0 [32];
    logic [7:0] mem1 [32];
    logic [7:0] mem2 [32];

    logic start0 = 0, abort0 = 0, done0, err0, busy0, pg0, rden0, aen0;
    logic [1:0] sel0 = '0;
    logic [7:0] addr0, rdata0;
    logic [63:0] data0;
    assign rdata0 = mem0[addr0[4:0]];

    logic start1 = 0, abort1 = 0, done1, err1, busy1, pg1, rden1, aen1;
    logic [1:0] sel1 = '0;
    logic [7:0] addr1, rdata1;
    logic [63:0] data1;
    assign rdata1 = mem1[addr1[4:0]];

    logic start2 = 0, abort2 = 0, done2, err2, busy2, pg2, rden2, aen2;
    logic [1:0] sel2 = '0;
    logic [7:0] addr2, rdata2;
    logic [95:0] data2;
    assign rdata2 = mem2[addr2[4:0]];

    efuse_read_ctrl #(.NR(64), .MEM_BYTES(32), .TRD_W(6), .TGAP_W(4), .BYTE_ORDER(0)) u0 (
        .clk(clk), .rst_n(rst_n), .rg_efuse_trd(trd), .rg_efuse_tgap(tgap), .read_sel(sel0),
        .read_start(start0), .read_abort(abort0), .read_done(done0), .read_err(err0), .read_data(data0),
        .busy_read(busy0), .efuse_pgmen_o(pg0), .efuse_rden_o(rden0), .efuse_aen_o(aen0),
        .efuse_addr_o(addr0), .efuse_rdata(rdata0));

    efuse_read_ctrl #(.NR(64), .MEM_BYTES(32), .TRD_W(6), .TGAP_W(4), .BYTE_ORDER(1)) u1 (
        .clk(clk), .rst_n(rst_n), .rg_efuse_trd(trd), .rg_efuse_tgap(tgap), .read_sel(sel1),
        .read_start(start1), .read_abort(abort1), .read_done(done1), .read_err(err1), .read_data(data1),
        .busy_read(busy1), .efuse_pgmen_o(pg1), .efuse_rden_o(rden1), .efuse_aen_o(aen1),
        .efuse_addr_o(addr1), .efuse_rdata(rdata1));

    efuse_read_ctrl #(.NR(96), .MEM_BYTES(32), .TRD_W(6), .TGAP_W(4), .BYTE_ORDER(0)) u2 (
        .clk(clk), .rst_n(rst_n), .rg_efuse_trd(trd), .rg_efuse_tgap(tgap), .read_sel(sel2),
        .read_start(start2), .read_abort(abort2), .read_done(done2), .read_err(err2), .read_data(data2),
        .busy_read(busy2), .efuse_pgmen_o(pg2), .efuse_rden_o(rden2), .efuse_aen_o(aen2),
        .efuse_addr_o(addr2), .efuse_rdata(rdata2));

    // expected word: bytes base..base+bn-1; order 0 puts the first byte at the top, order 1 at bit 0
    function automatic logic [95:0] model_word(input int which, input int sel, input int bn, input int order);
        logic [95:0] w;
        logic [7:0] b;
        w = '0;
        for (int i = 0; i < bn; i++) begin
            b = which == 0 ? mem0[sel * bn + i] : which == 1 ? mem1[sel * bn + i] : mem2[sel * bn + i];
            if (order == 0) w = (w << 8) | 96'(b);
            else w = w | (96'(b) << (8 * i));
        end
        return w;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 32; i++) begin
            mem0[i] = 8'($urandom);
            mem1[i] = 8'($urandom);
            mem2[i] = 8'($urandom);
        end
    endtask

    task automatic run_read0(input int sel, input int t_reg, input int g_reg, input bit disturb);
        int t, g, total, base, errs, first_j;
        logic [63:0] exp_w;
        logic e_busy, e_rden, e_aen, e_done;
        logic [7:0] e_addr;
        t = (t_reg < 1 ? 1 : t_reg) + 1;
        g = g_reg < 1 ? 1 : g_reg;
        total = 1 + 8 * (t + g);
        base = 8 * sel;
        errs = 0;
        first_j = -1;
        exp_w = 64'(model_word(0, sel, 8, 0));
        @(negedge clk);
        sel0 = 2'(sel); trd = 6'(t_reg); tgap = 4'(g_reg); start0 = 1;
        for (int j = 0; j <= total; j++) begin
            @(negedge clk);
            start0 = 0;
            if (disturb && j == 4) begin
                start0 = 1; trd = 6'($urandom); tgap = 4'($urandom); sel0 = 2'($urandom);
            end
            e_busy = j < total;
            e_rden = j < total;
            e_done = j == total;
            e_aen  = j >= 1 && j < total && ((j - 1) % (t + g)) < t;
            e_addr = j == total ? 8'(base + 7) : 8'(base + (j >= 1 ? (j - 1) / (t + g) : 0));
            if ({busy0, rden0, aen0, done0, err0, pg0} !== {e_busy, e_rden, e_aen, e_done, 1'b0, 1'b0} || addr0 !== e_addr) begin
                errs++;
                if (first_j < 0) first_j = j;
            end
        end
        tests++;
        if (errs != 0) begin
            fails++;
            $display("FAIL read_trace sel=%0d trd=%0d tgap=%0d: got %0d bad cycles (first at %0d), required 0", sel, t_reg, g_reg, errs, first_j);
        end
        tests++;
        if (data0 !== exp_w) begin
            fails++;
            $display("FAIL read_data sel=%0d: got %h required %h", sel, data0, exp_w);
        end
        @(negedge clk);
        tests++;
        if (busy0 !== 1'b0 || done0 !== 1'b1) begin
            fails++;
            $display("FAIL read_settle: got busy=%b done=%b required busy=0 done=1", busy0, done0);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(negedge clk);
        tests++;
        if ({done0, err0, busy0, pg0, rden0, aen0, addr0, data0, done1, busy1, data1, done2, busy2, data2} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got u0 done=%b err=%b busy=%b rden=%b aen=%b addr=%h data=%h, required all 0", done0, err0, busy0, rden0, aen0, addr0, data0);
        end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_read0(1, 3, 2, 0);
    endtask

    task automatic test_random_reads();
        for (int n = 0; n < 5; n++) begin
            fill_random();
            run_read0(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 5)), 0);
        end
    endtask

    task automatic test_min_timing_busy_start();
        fill_random();
        run_read0(1, 0, 0, 1);
        run_read0(3, 0, 0, 0);
    endtask

    task automatic test_abort();
        @(negedge clk);
        sel0 = 2; trd = 3; tgap = 2; start0 = 1;
        @(negedge clk);
        start0 = 0;
        repeat (14) @(negedge clk);
        tests++;
        if (aen0 !== 1'b1 || addr0 !== 8'd18) begin
            fails++;
            $display("FAIL abort_third_strobe: got aen=%b addr=%0d required aen=1 addr=18", aen0, addr0);
        end
        abort0 = 1;
        @(negedge clk);
        abort0 = 0;
        tests++;
        if ({aen0, rden0, busy0, err0, done0} !== 5'b00010 || data0 !== '0) begin
            fails++;
            $display("FAIL abort_result: got aen=%b rden=%b busy=%b err=%b done=%b data=%h required 0,0,0,1,0 data 0", aen0, rden0, busy0, err0, done0, data0);
        end
        fill_random();
        run_read0(int'($urandom_range(0, 3)), 3, 2, 0);
    endtask

    task automatic test_abort_idle();
        logic [63:0] saved;
        saved = data0;
        @(negedge clk);
        abort0 = 1;
        @(negedge clk);
        abort0 = 0;
        tests++;
        if (done0 !== 1'b1 || err0 !== 1'b0 || data0 !== saved) begin
            fails++;
            $display("FAIL abort_idle: got done=%b err=%b data=%h required done=1 err=0 data=%h", done0, err0, data0, saved);
        end
        start0 = 1; abort0 = 1;
        @(negedge clk);
        start0 = 0; abort0 = 0;
        @(negedge clk);
        tests++;
        if (busy0 !== 1'b0 || rden0 !== 1'b0 || done0 !== 1'b1 || data0 !== saved) begin
            fails++;
            $display("FAIL abort_beats_start: got busy=%b rden=%b done=%b data=%h required busy=0 rden=0 done=1 data=%h", busy0, rden0, done0, data0, saved);
        end
    endtask

    task automatic test_byte_order();
        logic [63:0] exp_w;
        int n;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) mem1[i] = k == 0 ? 8'(i) : 8'($urandom);
            @(negedge clk);
            sel1 = k == 0 ? 2'd0 : 2'd3; trd = 6'($urandom_range(0, 4)); tgap = 4'($urandom_range(0, 3)); start1 = 1;
            exp_w = k == 0 ? 64'h0706050403020100 : 64'(model_word(1, 3, 8, 1));
            @(negedge clk);
            start1 = 0;
            n = 0;
            while (done1 !== 1'b1 && n < 400) begin
                @(negedge clk);
                n++;
            end
            tests++;
            if (done1 !== 1'b1 || data1 !== exp_w || err1 !== 1'b0) begin
                fails++;
                $display("FAIL byte_order_%0d: got done=%b err=%b data=%h required done=1 err=0 data=%h", k, done1, err1, data1, exp_w);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [95:0] exp_w;
        int n;
        for (int s = 2; s < 4; s++) begin
            @(negedge clk);
            sel2 = 2'(s); trd = 3; tgap = 2; start2 = 1;
            @(negedge clk);
            start2 = 0;
            tests++;
            if ({busy2, rden2, aen2, done2, err2} !== 5'b10000) begin
                fails++;
                $display("FAIL oor_first_cycle sel=%0d: got busy=%b rden=%b aen=%b done=%b err=%b required 1,0,0,0,0", s, busy2, rden2, aen2, done2, err2);
            end
            @(negedge clk);
            tests++;
            if ({busy2, rden2, aen2, done2, err2} !== 5'b00011 || data2 !== '0) begin
                fails++;
                $display("FAIL oor_result sel=%0d: got busy=%b rden=%b aen=%b done=%b err=%b data=%h required 0,0,0,1,1 data 0", s, busy2, rden2, aen2, done2, err2, data2);
            end
        end
        @(negedge clk);
        sel2 = 1; start2 = 1;
        exp_w = model_word(2, 1, 12, 0);
        @(negedge clk);
        start2 = 0;
        n = 0;
        while (done2 !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (done2 !== 1'b1 || err2 !== 1'b0 || data2 !== exp_w) begin
            fails++;
            $display("FAIL nr96_read: got done=%b err=%b data=%h required done=1 err=0 data=%h", done2, err2, data2, exp_w);
        end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        sel0 = 0; trd = 3; tgap = 2; start0 = 1;
        @(negedge clk);
        start0 = 0;
        repeat (5) @(negedge clk);
        #2 rst_n = 0;
        #1;
        tests++;
        if ({done0, err0, busy0, rden0, aen0, addr0, data0} !== '0) begin
            fails++;
            $display("FAIL reset_mid_read: got done=%b err=%b busy=%b rden=%b aen=%b addr=%h data=%h required all 0", done0, err0, busy0, rden0, aen0, addr0, data0);
        end
        @(negedge clk);
        rst_n = 1;
        fill_random();
        run_read0(int'($urandom_range(0, 3)), 2, 1, 0);
    endtask

    initial begin
        fill_random();
        test_reset();
        test_basic();
        test_random_reads();
        test_min_timing_busy_start();
        test_abort();
        test_abort_idle();
        test_byte_order();
        test_out_of_range();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
